// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter
// Description : Shares the single register-file write port between the
//               in-order MEM/WB writeback slot and out-of-band long-latency
//               results (mul/div, load-miss refill). Long-latency results are
//               buffered in a small FIFO and drained into idle writeback
//               cycles. Younger pipeline writes kill stale buffered results to
//               the same register. A starvation counter forces a drain by
//               stalling the pipeline writeback.
// Ports       : clk, reset (async, active-low)
//               wb_valid/wb_dest/wb_data   : MEM/WB write request
//               ll_valid/ll_dest/ll_data   : long-latency result offer
//               ll_ready                   : buffer can accept this cycle
//               rf_we/rf_waddr/rf_wdata    : register-file write port
//               pipe_stall                 : MEM/WB write not taken, hold
//               pend_mask                  : dests of valid buffered entries
// Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter #(
  parameter int DATA_WIDTH   = 64,
  parameter int NUM_REGS_LOG = 5,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wb_valid,
  input  logic [NUM_REGS_LOG-1:0]    wb_dest,
  input  logic [DATA_WIDTH-1:0]      wb_data,
  input  logic                       ll_valid,
  input  logic [NUM_REGS_LOG-1:0]    ll_dest,
  input  logic [DATA_WIDTH-1:0]      ll_data,
  output logic                       ll_ready,
  output logic                       rf_we,
  output logic [NUM_REGS_LOG-1:0]    rf_waddr,
  output logic [DATA_WIDTH-1:0]      rf_wdata,
  output logic                       pipe_stall,
  output logic [2**NUM_REGS_LOG-1:0] pend_mask
);

  localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CNT_W = $clog2(DEPTH + 1);
  localparam int c_STV_W = $clog2(STARVE_LIMIT + 1);

  // Buffer storage
  logic [DEPTH-1:0]                       r_vld;
  logic [DEPTH-1:0][NUM_REGS_LOG-1:0]     r_dest;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]       r_data;
  logic [c_PTR_W-1:0]                     r_rd_ptr;
  logic [c_PTR_W-1:0]                     r_wr_ptr;
  logic [c_CNT_W-1:0]                     r_count;
  logic [c_STV_W-1:0]                     r_starve;

  logic                       w_empty;
  logic                       w_head_present;
  logic                       w_head_valid;
  logic                       w_wb_req;
  logic                       w_force;
  logic                       w_wb_grant;
  logic                       w_head_wr;
  logic                       w_bypass;
  logic                       w_pop;
  logic                       w_accept;
  logic                       w_discard;
  logic                       w_enq;
  logic                       w_ready;
  logic                       w_we;
  logic                       w_stall;
  logic [NUM_REGS_LOG-1:0]    w_waddr;
  logic [DATA_WIDTH-1:0]      w_wdata;
  logic [2**NUM_REGS_LOG-1:0] w_pend;

  assign w_empty        = (r_count == '0);
  assign w_head_present = !w_empty;
  assign w_head_valid   = w_head_present && r_vld[r_rd_ptr];
  assign w_wb_req       = wb_valid && (wb_dest != '0);
  assign w_ready        = (r_count < c_CNT_W'(DEPTH));
  assign w_force        = w_head_valid && (r_starve == c_STV_W'(STARVE_LIMIT)) && w_wb_req;

  // Port arbitration, first match wins
  always_comb begin
    w_we       = 1'b0;
    w_waddr    = '0;
    w_wdata    = '0;
    w_stall    = 1'b0;
    w_wb_grant = 1'b0;
    w_head_wr  = 1'b0;
    w_bypass   = 1'b0;
    if (w_force) begin
      w_we      = 1'b1;
      w_waddr   = r_dest[r_rd_ptr];
      w_wdata   = r_data[r_rd_ptr];
      w_stall   = 1'b1;
      w_head_wr = 1'b1;
    end else if (w_wb_req) begin
      w_we       = 1'b1;
      w_waddr    = wb_dest;
      w_wdata    = wb_data;
      w_wb_grant = 1'b1;
    end else if (w_head_valid) begin
      w_we      = 1'b1;
      w_waddr   = r_dest[r_rd_ptr];
      w_wdata   = r_data[r_rd_ptr];
      w_head_wr = 1'b1;
    end else if (w_empty && ll_valid && (ll_dest != '0)) begin
      w_we     = 1'b1;
      w_waddr  = ll_dest;
      w_wdata  = ll_data;
      w_bypass = 1'b1;
    end
  end

  // A killed head is retired silently whenever no valid-head pop happens;
  // since a killed head is never also written, this never yields two pops.
  assign w_pop     = w_head_wr || (w_head_present && !w_head_valid);
  assign w_accept  = ll_valid && w_ready;
  // An ll result to the same register as a granted wb write is older, so it
  // is dropped rather than enqueued behind the younger value.
  assign w_discard = (ll_dest == '0) || (w_wb_grant && (wb_dest == ll_dest));
  assign w_enq     = w_accept && !w_bypass && !w_discard;

  always_comb begin
    w_pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i]) begin
        w_pend[r_dest[i]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld    <= '0;
      r_dest   <= '0;
      r_data   <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_starve <= '0;
    end else begin
      // WAW kill from a granted wb write
      if (w_wb_grant) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (r_dest[i] == wb_dest) begin
            r_vld[i] <= 1'b0;
          end
        end
      end
      if (w_pop) begin
        r_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr        <= r_rd_ptr + 1'b1;
      end
      // Enqueue slot differs from the pop slot: enq needs non-full, pop
      // needs non-empty, and the pointers only coincide at empty or full.
      if (w_enq) begin
        r_vld[r_wr_ptr]  <= 1'b1;
        r_dest[r_wr_ptr] <= ll_dest;
        r_data[r_wr_ptr] <= ll_data;
        r_wr_ptr         <= r_wr_ptr + 1'b1;
      end
      case ({w_enq, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_head_valid && !w_head_wr) begin
        if (r_starve != c_STV_W'(STARVE_LIMIT)) begin
          r_starve <= r_starve + 1'b1;
        end
      end else begin
        r_starve <= '0;
      end
    end
  end

  // Outputs are gated by reset so a held-low reset blocks writes driven
  // purely by the wb inputs.
  assign ll_ready   = reset && w_ready;
  assign rf_we      = reset && w_we;
  assign rf_waddr   = w_waddr;
  assign rf_wdata   = w_wdata;
  assign pipe_stall = reset && w_stall;
  assign pend_mask  = reset ? w_pend : '0;

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_port_arbiter
// Description : Self-checking bench for wb_port_arbiter: a directed vector
//               table, a reset-while-full sequence and randomized traffic
//               against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;

  logic        clk;
  logic        reset;
  logic        wb_valid;
  logic [4:0]  wb_dest;
  logic [63:0] wb_data;
  logic        ll_valid;
  logic [4:0]  ll_dest;
  logic [63:0] ll_data;
  logic        ll_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic        pipe_stall;
  logic [31:0] pend_mask;

  int n_tests = 0;
  int n_fail  = 0;

  wb_port_arbiter #(
    .DATA_WIDTH  (64),
    .NUM_REGS_LOG(5),
    .DEPTH       (2),
    .STARVE_LIMIT(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wb_valid  (wb_valid),
    .wb_dest   (wb_dest),
    .wb_data   (wb_data),
    .ll_valid  (ll_valid),
    .ll_dest   (ll_dest),
    .ll_data   (ll_data),
    .ll_ready  (ll_ready),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .pipe_stall(pipe_stall),
    .pend_mask (pend_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic wv, input logic [4:0] wd, input logic [63:0] wdat,
                       input logic lv, input logic [4:0] ld, input logic [63:0] ldat);
    wb_valid = wv; wb_dest = wd; wb_data = wdat;
    ll_valid = lv; ll_dest = ld; ll_data = ldat;
  endtask

  // Directed vectors: inputs plus expected combinational outputs
  typedef struct {
    logic        wv; logic [4:0] wd; logic [63:0] wdat;
    logic        lv; logic [4:0] ld; logic [63:0] ldat;
    logic        e_we; logic [4:0] e_addr; logic [63:0] e_data;
    logic        e_stall; logic e_rdy; logic [31:0] e_pend;
  } vec_t;
  vec_t tv[$];

  task automatic add(input logic wv, input logic [4:0] wd, input logic [63:0] wdat,
                     input logic lv, input logic [4:0] ld, input logic [63:0] ldat,
                     input logic e_we, input logic [4:0] e_addr, input logic [63:0] e_data,
                     input logic e_stall, input logic e_rdy, input logic [31:0] e_pend);
    vec_t v;
    v.wv = wv; v.wd = wd; v.wdat = wdat; v.lv = lv; v.ld = ld; v.ldat = ldat;
    v.e_we = e_we; v.e_addr = e_addr; v.e_data = e_data;
    v.e_stall = e_stall; v.e_rdy = e_rdy; v.e_pend = e_pend;
    tv.push_back(v);
  endtask

  // Reference model: buffer as a queue of {valid, dest, data}
  typedef struct { bit vld; logic [4:0] dest; logic [63:0] data; } ent_t;
  ent_t mq[$];
  int   m_starve;

  task automatic model_cycle(input logic wv, input logic [4:0] wd, input logic [63:0] wdat,
                             input logic lv, input logic [4:0] ld, input logic [63:0] ldat,
                             output logic e_we, output logic [4:0] e_addr,
                             output logic [63:0] e_data, output logic e_stall,
                             output logic e_rdy, output logic [31:0] e_pend);
    bit hv, wbreq, grant, head_wr, byp, keep;
    ent_t n;
    hv    = (mq.size() > 0) && mq[0].vld;
    wbreq = wv && (wd != 0);
    e_rdy = (mq.size() < 2);
    e_pend = '0;
    foreach (mq[i]) if (mq[i].vld) e_pend[mq[i].dest] = 1'b1;
    e_we = 0; e_addr = 0; e_data = 0; e_stall = 0;
    grant = 0; head_wr = 0; byp = 0;
    if (hv && m_starve == 4 && wbreq) begin
      e_we = 1; e_addr = mq[0].dest; e_data = mq[0].data; e_stall = 1; head_wr = 1;
    end else if (wbreq) begin
      e_we = 1; e_addr = wd; e_data = wdat; grant = 1;
    end else if (hv) begin
      e_we = 1; e_addr = mq[0].dest; e_data = mq[0].data; head_wr = 1;
    end else if (mq.size() == 0 && lv && ld != 0) begin
      e_we = 1; e_addr = ld; e_data = ldat; byp = 1;
    end
    keep = lv && e_rdy && !byp && (ld != 0) && !(grant && ld == wd);
    if (hv && !head_wr) m_starve = (m_starve < 4) ? m_starve + 1 : 4;
    else m_starve = 0;
    if (head_wr || (mq.size() > 0 && !mq[0].vld)) void'(mq.pop_front());
    if (grant) foreach (mq[i]) if (mq[i].dest == wd) mq[i].vld = 0;
    if (keep) begin
      n.vld = 1; n.dest = ld; n.data = ldat;
      mq.push_back(n);
    end
  endtask

  task automatic check_outs(input string tag, input logic e_we, input logic [4:0] e_addr,
                            input logic [63:0] e_data, input logic e_stall,
                            input logic e_rdy, input logic [31:0] e_pend);
    chk({tag, ".rf_we"}, {63'd0, rf_we}, {63'd0, e_we});
    if (e_we) begin
      chk({tag, ".rf_waddr"}, {59'd0, rf_waddr}, {59'd0, e_addr});
      chk({tag, ".rf_wdata"}, rf_wdata, e_data);
    end
    chk({tag, ".pipe_stall"}, {63'd0, pipe_stall}, {63'd0, e_stall});
    chk({tag, ".ll_ready"}, {63'd0, ll_ready}, {63'd0, e_rdy});
    chk({tag, ".pend_mask"}, {32'd0, pend_mask}, {32'd0, e_pend});
  endtask

  initial begin
    logic        e_we, e_stall, e_rdy;
    logic [4:0]  e_addr;
    logic [63:0] e_data;
    logic [31:0] e_pend;

    reset = 1'b0;
    drive(1, 5'd3, 64'h33, 1, 5'd7, 64'hAA);
    repeat (2) @(posedge clk);
    #1;
    chk("reset.rf_we", {63'd0, rf_we}, 64'd0);
    chk("reset.ll_ready", {63'd0, ll_ready}, 64'd0);
    chk("reset.pipe_stall", {63'd0, pipe_stall}, 64'd0);
    chk("reset.pend_mask", {32'd0, pend_mask}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);

    // Bypass to an idle port
    add(0,0,0,        1,7,64'hAA, 1,7,64'hAA, 0,1,32'h0);
    add(0,0,0,        0,0,0,      0,0,0,      0,1,32'h0);
    // Starvation: wb dest 3 every cycle, ll dest 5 and 6 buffered
    add(1,3,64'h33,   1,5,64'h55, 1,3,64'h33, 0,1,32'h0);
    add(1,3,64'h33,   1,6,64'h66, 1,3,64'h33, 0,1,32'h20);
    add(1,3,64'h33,   0,0,0,      1,3,64'h33, 0,0,32'h60);
    add(1,3,64'h33,   0,0,0,      1,3,64'h33, 0,0,32'h60);
    add(1,3,64'h33,   0,0,0,      1,3,64'h33, 0,0,32'h60);
    add(1,3,64'h33,   0,0,0,      1,5,64'h55, 1,0,32'h60);
    add(1,3,64'h33,   0,0,0,      1,3,64'h33, 0,1,32'h40);
    add(1,3,64'h33,   0,0,0,      1,3,64'h33, 0,1,32'h40);
    add(1,3,64'h33,   0,0,0,      1,3,64'h33, 0,1,32'h40);
    add(1,3,64'h33,   0,0,0,      1,3,64'h33, 0,1,32'h40);
    add(1,3,64'h33,   0,0,0,      1,6,64'h66, 1,1,32'h40);
    add(0,0,0,        0,0,0,      0,0,0,      0,1,32'h0);
    // WAW kill of buffered dest 9
    add(1,3,64'h33,   1,9,64'h99, 1,3,64'h33, 0,1,32'h0);
    add(1,9,64'h11,   0,0,0,      1,9,64'h11, 0,1,32'h200);
    add(0,0,0,        0,0,0,      0,0,0,      0,1,32'h0);
    add(0,0,0,        0,0,0,      0,0,0,      0,1,32'h0);
    // Same-cycle wb and ll to dest 4: ll dropped
    add(1,4,64'h44,   1,4,64'h77, 1,4,64'h44, 0,1,32'h0);
    add(0,0,0,        0,0,0,      0,0,0,      0,1,32'h0);
    // wb to x0 does not block the head; ll to x0 dropped
    add(1,3,64'h33,   1,2,64'h22, 1,3,64'h33, 0,1,32'h0);
    add(1,0,64'hF0,   1,0,64'hE0, 1,2,64'h22, 0,1,32'h4);
    add(0,0,0,        0,0,0,      0,0,0,      0,1,32'h0);

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      drive(tv[i].wv, tv[i].wd, tv[i].wdat, tv[i].lv, tv[i].ld, tv[i].ldat);
      #1;
      check_outs($sformatf("vec%0d", i), tv[i].e_we, tv[i].e_addr, tv[i].e_data,
                 tv[i].e_stall, tv[i].e_rdy, tv[i].e_pend);
    end

    // Fill the buffer, then reset while full
    @(negedge clk); drive(1, 5'd3, 64'h33, 1, 5'd10, 64'hA0);
    @(negedge clk); drive(1, 5'd3, 64'h33, 1, 5'd11, 64'hB0);
    @(negedge clk); drive(1, 5'd3, 64'h33, 0, 0, 0);
    #1;
    chk("full.ll_ready", {63'd0, ll_ready}, 64'd0);
    chk("full.pend_mask", {32'd0, pend_mask}, 64'h0C00);
    #2;
    reset = 1'b0;
    #1;
    chk("rstmid.rf_we", {63'd0, rf_we}, 64'd0);
    chk("rstmid.ll_ready", {63'd0, ll_ready}, 64'd0);
    chk("rstmid.pend_mask", {32'd0, pend_mask}, 64'd0);
    chk("rstmid.pipe_stall", {63'd0, pipe_stall}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("rstrel.ll_ready", {63'd0, ll_ready}, 64'd1);
    chk("rstrel.rf_we", {63'd0, rf_we}, 64'd0);
    chk("rstrel.pend_mask", {32'd0, pend_mask}, 64'd0);
    @(negedge clk);
    #1;
    chk("rstrel2.rf_we", {63'd0, rf_we}, 64'd0);

    // Randomized traffic against the reference model
    mq.delete();
    m_starve = 0;
    for (int c = 0; c < 600; c++) begin
      logic        wv, lv;
      logic [4:0]  wd, ld;
      logic [63:0] wdat, ldat;
      @(negedge clk);
      wv   = ($urandom_range(0, 99) < 65);
      wd   = 5'($urandom_range(0, 7));
      wdat = {$urandom, $urandom};
      lv   = ($urandom_range(0, 99) < 45);
      ld   = 5'($urandom_range(0, 7));
      ldat = {$urandom, $urandom};
      drive(wv, wd, wdat, lv, ld, ldat);
      #1;
      model_cycle(wv, wd, wdat, lv, ld, ldat, e_we, e_addr, e_data, e_stall, e_rdy, e_pend);
      check_outs($sformatf("rnd%0d", c), e_we, e_addr, e_data, e_stall, e_rdy, e_pend);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
